// File: rtl/task_2_result_streamer.sv
// Result staging buffer for the task-2 solver: the core fills words by address, commits,
// and the block then arms the output FIFO stage and streams the packet in address order.
module task_2_result_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_WORDS  = 81,
  parameter int ADDR_WIDTH = $clog2(NUM_WORDS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_commit,
  output logic                  o_wr_ready,
  input  logic                  i_out_busy,
  input  logic                  i_out_full,
  output logic                  o_input_last,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_data_valid,
  output logic                  o_done,
  output logic                  o_err
);

  typedef enum logic [2:0] {
    S_FILL,
    S_WAIT,
    S_ARM,
    S_STREAM,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_WORDS - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
  logic [DATA_WIDTH-1:0] mem_d [NUM_WORDS];
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  in_fill;
  logic                  wr_in_range;
  logic                  wr_accept;
  logic                  proto_err;
  logic [ADDR_WIDTH-1:0] rd_idx;

  assign in_fill     = (state_q == S_FILL);
  assign wr_in_range = (i_wr_addr <= LAST_ADDR);
  assign wr_accept   = i_wr_en && in_fill && wr_in_range;
  assign proto_err   = (i_wr_en && (!in_fill || !wr_in_range)) || (i_commit && !in_fill);
  assign rd_idx      = cnt_q + ADDR_WIDTH'(1);

  // Storage keeps its contents between packets; only accepted writes modify it.
  always_comb begin
    for (int i = 0; i < NUM_WORDS; i++) begin
      mem_d[i] = mem_q[i];
      if (wr_accept && (i_wr_addr == ADDR_WIDTH'(i))) begin
        mem_d[i] = i_wr_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = '0;
    valid_d = 1'b0;
    last_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = err_q | proto_err;

    case (state_q)
      S_FILL: begin
        if (i_commit) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (!i_out_busy && !i_out_full) begin
          state_d = S_ARM;
          last_d  = 1'b1;
        end
      end
      // Word 0 is fetched while arming so it lands the cycle after o_input_last.
      S_ARM: begin
        state_d = S_STREAM;
        cnt_d   = '0;
        data_d  = mem_q[0];
        valid_d = 1'b1;
      end
      S_STREAM: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          cnt_d   = rd_idx;
          data_d  = mem_q[rd_idx];
          valid_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_FILL;
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_FILL;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < NUM_WORDS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
      mem_q   <= mem_d;
    end
  end

  assign o_wr_ready   = in_fill && !i_rst;
  assign o_input_last = last_q;
  assign o_data       = data_q;
  assign o_data_valid = valid_q;
  assign o_done       = done_q;
  assign o_err        = err_q;

  a_cnt_bound: assert property (@(posedge i_clk) disable iff (i_rst) cnt_q <= LAST_ADDR);
  a_valid_in_stream: assert property (@(posedge i_clk) disable iff (i_rst)
    valid_q |-> (state_q == S_STREAM));
  a_last_in_arm: assert property (@(posedge i_clk) disable iff (i_rst)
    last_q |-> (state_q == S_ARM));
  a_done_in_done: assert property (@(posedge i_clk) disable iff (i_rst)
    done_q |-> (state_q == S_DONE));

endmodule

// File: tb/tb_task_2_result_streamer.sv
// Directed bench for task_2_result_streamer: stimulus pushes expected stream words into a
// queue at commit time; an independent monitor pops and compares every valid word.
module tb_task_2_result_streamer;

  localparam int DW = 8;
  localparam int NW = 81;
  localparam int AW = 7;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_wr_en = 1'b0;
  logic [AW-1:0] i_wr_addr = '0;
  logic [DW-1:0] i_wr_data = '0;
  logic          i_commit = 1'b0;
  logic          o_wr_ready;
  logic          i_out_busy = 1'b0;
  logic          i_out_full = 1'b0;
  logic          o_input_last;
  logic [DW-1:0] o_data;
  logic          o_data_valid;
  logic          o_done;
  logic          o_err;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_mem[NW];
  logic [DW-1:0] mon_exp;

  task_2_result_streamer #(.DATA_WIDTH(DW), .NUM_WORDS(NW), .ADDR_WIDTH(AW)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_wr_en      (i_wr_en),
    .i_wr_addr    (i_wr_addr),
    .i_wr_data    (i_wr_data),
    .i_commit     (i_commit),
    .o_wr_ready   (o_wr_ready),
    .i_out_busy   (i_out_busy),
    .i_out_full   (i_out_full),
    .o_input_last (o_input_last),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Scoreboard monitor: every valid word must match the head of the queue.
  always @(negedge i_clk) begin
    if (o_data_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("stream_word", {24'd0, o_data}, {24'd0, mon_exp});
      end
    end else if (!i_rst && o_data !== '0) begin
      chk("idle_data_zero", {24'd0, o_data}, 32'd0);
    end
  end

  // All drive tasks start on a negedge and return on the following negedge.
  task automatic wr(input int addr, input logic [DW-1:0] data, input bit good);
    i_wr_en   = 1'b1;
    i_wr_addr = AW'(addr);
    i_wr_data = data;
    if (good) exp_mem[addr] = data;
    @(negedge i_clk);
    i_wr_en = 1'b0;
  endtask

  task automatic commit(input bit with_wr, input int addr, input logic [DW-1:0] data);
    i_commit = 1'b1;
    if (with_wr) begin
      i_wr_en   = 1'b1;
      i_wr_addr = AW'(addr);
      i_wr_data = data;
      exp_mem[addr] = data;
    end
    for (int i = 0; i < NW; i++) exp_q.push_back(exp_mem[i]);
    @(negedge i_clk);
    i_commit = 1'b0;
    i_wr_en  = 1'b0;
  endtask

  task automatic stream(input int hold, input int inject_at, input int rst_at);
    int  n;
    bit  quiet;
    if (hold > 0) begin
      quiet = 1'b1;
      repeat (hold) begin
        @(negedge i_clk);
        if (o_input_last || o_data_valid) quiet = 1'b0;
      end
      chk("held_no_arm", {31'd0, quiet}, 32'd1);
      i_out_busy = 1'b0;
      i_out_full = 1'b0;
    end
    n = 0;
    do begin
      @(negedge i_clk);
      n++;
    end while (!o_input_last && n < 200);
    chk("arm_latency", n, 32'd1);
    for (int k = 0; k < NW; k++) begin
      @(negedge i_clk);
      if (k == 0) chk("arm_one_cycle", {31'd0, o_input_last}, 32'd0);
      if (k == inject_at + 1) begin
        i_wr_en  = 1'b0;
        i_commit = 1'b0;
      end
      if (k == inject_at) begin
        i_wr_en   = 1'b1;
        i_wr_addr = '0;
        i_wr_data = 8'hAA;
        i_commit  = 1'b1;
      end
      if (k == rst_at) begin
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("rst_valid_low", {31'd0, o_data_valid}, 32'd0);
        chk("rst_data_zero", {24'd0, o_data}, 32'd0);
        chk("rst_wr_ready_low", {31'd0, o_wr_ready}, 32'd0);
        i_rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < NW; i++) exp_mem[i] = '0;
        @(negedge i_clk);
        chk("rst_wr_ready_back", {31'd0, o_wr_ready}, 32'd1);
        quiet = 1'b1;
        repeat (100) begin
          @(negedge i_clk);
          if (o_done || o_data_valid) quiet = 1'b0;
        end
        chk("rst_no_done", {31'd0, quiet}, 32'd1);
        return;
      end
    end
    @(negedge i_clk);
    chk("done_pulse", {31'd0, o_done}, 32'd1);
    chk("valid_after_last", {31'd0, o_data_valid}, 32'd0);
    chk("queue_drained", exp_q.size(), 32'd0);
    @(negedge i_clk);
    chk("done_one_cycle", {31'd0, o_done}, 32'd0);
    chk("wr_ready_back", {31'd0, o_wr_ready}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < NW; i++) exp_mem[i] = '0;
    repeat (3) @(negedge i_clk);
    chk("reset_wr_ready", {31'd0, o_wr_ready}, 32'd0);
    chk("reset_valid", {31'd0, o_data_valid}, 32'd0);
    chk("reset_last", {31'd0, o_input_last}, 32'd0);
    chk("reset_done", {31'd0, o_done}, 32'd0);
    chk("reset_err", {31'd0, o_err}, 32'd0);
    chk("reset_data", {24'd0, o_data}, 32'd0);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("fill_wr_ready", {31'd0, o_wr_ready}, 32'd1);

    // Packet of 1..81, output stage idle.
    for (int k = 0; k < NW; k++) wr(k, 8'(k + 1), 1'b1);
    commit(1'b0, 0, '0);
    stream(0, -1, -1);

    // Same buffer resent while the output stage reports busy for 20 cycles.
    i_out_busy = 1'b1;
    commit(1'b0, 0, '0);
    stream(20, -1, -1);

    // Write to the last address in the commit cycle.
    chk("err_clean_before_edge", {31'd0, o_err}, 32'd0);
    commit(1'b1, 80, 8'h5C);
    stream(0, -1, -1);
    chk("err_clean_after_edge", {31'd0, o_err}, 32'd0);

    // Out-of-range writes are dropped and flag an error; full holds off arming.
    wr(5, 8'h33, 1'b1);
    wr(81, 8'hFF, 1'b0);
    chk("err_addr81", {31'd0, o_err}, 32'd1);
    wr(127, 8'hFF, 1'b0);
    i_out_full = 1'b1;
    commit(1'b0, 0, '0);
    stream(5, -1, -1);
    chk("err_sticky", {31'd0, o_err}, 32'd1);

    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    for (int i = 0; i < NW; i++) exp_mem[i] = '0;
    @(negedge i_clk);
    chk("err_cleared_by_reset", {31'd0, o_err}, 32'd0);

    // Write and commit injected mid-stream are ignored but flagged.
    for (int k = 0; k < NW; k++) wr(k, 8'(2 * k + 3), 1'b1);
    commit(1'b0, 0, '0);
    stream(0, 10, -1);
    chk("err_midstream", {31'd0, o_err}, 32'd1);
    commit(1'b0, 0, '0);
    stream(0, -1, -1);

    // Reset at stream word 40 abandons the packet and clears the buffer.
    commit(1'b0, 0, '0);
    stream(0, -1, 40);
    chk("err_after_reset", {31'd0, o_err}, 32'd0);
    commit(1'b0, 0, '0);
    stream(0, -1, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
